// File: rtl/mem_stage_pkg.sv
// Shared constants, state encoding and byte-lane helpers for the memory-access stage.
package mem_stage_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_TAIL   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Index of the last byte of the access: 1, 2 or 4 bytes wide.
    function automatic logic [1:0] last_byte_idx(input logic [2:0] funct3);
        logic [1:0] idx;
        case (funct3[1:0])
            2'b00:   idx = 2'd0;
            2'b01:   idx = 2'd1;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] w;
        w = word;
        case (idx)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            default: w[31:24] = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Arbiter request/grant plus the shared byte-wide RAM bus seen by the memory stage.
interface mem_stage_if #(
    parameter int ADDR_W = 32
) ();
    logic              mem_req;
    logic              mem_grant;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    modport master (
        output mem_req,
        output ram_addr,
        output ram_wr,
        output ram_dout,
        input  mem_grant,
        input  ram_din
    );

    modport slave (
        input  mem_req,
        input  ram_addr,
        input  ram_wr,
        input  ram_dout,
        output mem_grant,
        output ram_din
    );
endinterface

// File: rtl/mem_stage_load_extend.sv
// Width selection and sign/zero extension of the assembled load buffer.
module mem_stage_load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] lbuf,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    // funct3[2] selects zero extension for the byte and halfword forms.
    always_comb begin
        result = ZERO_WORD;
        case ({1'b0, funct3[1:0]})
            F3_LB:   result = funct3[2] ? {24'h00_0000, lbuf[7:0]}
                                        : {{24{lbuf[7]}}, lbuf[7:0]};
            F3_LH:   result = funct3[2] ? {16'h0000, lbuf[15:0]}
                                        : {{16{lbuf[15]}}, lbuf[15:0]};
            default: result = lbuf;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: ALU results pass through; loads/stores run byte-serially on the
// shared RAM bus after arbitration while the upstream pipeline is stalled.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        forward,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_val,
    input  logic [6:0]  ins_type,
    input  logic [2:0]  ins_details,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_val,
    output logic        output_forward,
    output logic [4:0]  output_rd_addr,
    output logic [31:0] output_rd_val,
    output logic        stall_req,
    mem_stage_if.master bus
);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] lbuf_q, lbuf_d;

    logic        is_load_s;
    logic        is_store_s;
    logic        is_mem_s;
    logic [1:0]  last_idx_s;
    logic [31:0] addr_sum_s;
    logic [31:0] load_val_s;

    assign is_load_s  = (ins_type == OP_LOAD);
    assign is_store_s = (ins_type == OP_STORE);
    assign is_mem_s   = is_load_s | is_store_s;
    assign last_idx_s = last_byte_idx(ins_details);
    assign addr_sum_s = mem_addr + {30'd0, cnt_q};

    mem_stage_load_extend u_load_extend (
        .lbuf   (lbuf_q),
        .funct3 (ins_details),
        .result (load_val_s)
    );

    // State, byte counter and load buffer registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            lbuf_q  <= ZERO_WORD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lbuf_q  <= lbuf_d;
        end
    end

    // Next-state logic; read data trails the address by one cycle, hence the TAIL state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lbuf_d  = lbuf_q;
        if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_mem_s) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_grant) begin
                        state_d = ST_ACCESS;
                        cnt_d   = 2'd0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_ACCESS: begin
                    if (is_load_s && (cnt_q != 2'd0)) begin
                        lbuf_d = put_byte(lbuf_q, cnt_q - 2'd1, bus.ram_din);
                    end else begin
                        lbuf_d = lbuf_q;
                    end
                    if (cnt_q == last_idx_s) begin
                        state_d = is_load_s ? ST_TAIL : ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                ST_TAIL: begin
                    lbuf_d  = put_byte(lbuf_q, last_idx_s, bus.ram_din);
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output decode per state; reset forces every output low regardless of state.
    always_comb begin
        output_forward = forward;
        output_rd_addr = rd_addr;
        output_rd_val  = rd_val;
        stall_req      = 1'b0;
        bus.mem_req    = 1'b0;
        bus.ram_wr     = 1'b0;
        bus.ram_addr   = {ADDR_W{1'b0}};
        bus.ram_dout   = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (is_mem_s) begin
                    output_forward = 1'b0;
                    stall_req      = 1'b1;
                    bus.mem_req    = 1'b1;
                end else begin
                    output_forward = forward;
                end
            end
            ST_WAIT: begin
                output_forward = 1'b0;
                stall_req      = 1'b1;
                bus.mem_req    = 1'b1;
            end
            ST_ACCESS: begin
                output_forward = 1'b0;
                stall_req      = 1'b1;
                bus.mem_req    = 1'b1;
                bus.ram_addr   = addr_sum_s[ADDR_W-1:0];
                if (is_store_s) begin
                    bus.ram_wr   = rdy_in;
                    bus.ram_dout = get_byte(mem_val, cnt_q);
                end else begin
                    bus.ram_wr   = 1'b0;
                end
            end
            ST_TAIL: begin
                output_forward = 1'b0;
                stall_req      = 1'b1;
                bus.mem_req    = 1'b1;
                bus.ram_addr   = addr_sum_s[ADDR_W-1:0];
            end
            ST_DONE: begin
                output_rd_val = is_load_s ? load_val_s : rd_val;
            end
            default: begin
                output_forward = 1'b0;
            end
        endcase
        if (rst_in) begin
            output_forward = 1'b0;
            output_rd_addr = 5'd0;
            output_rd_val  = ZERO_WORD;
            stall_req      = 1'b0;
            bus.mem_req    = 1'b0;
            bus.ram_wr     = 1'b0;
            bus.ram_addr   = {ADDR_W{1'b0}};
            bus.ram_dout   = 8'h00;
        end else begin
            bus.ram_wr     = bus.ram_wr & rdy_in;
        end
    end

endmodule
